// File: rtl/data_sram_responder.sv
// Data-SRAM port responder: word-addressed RAM plus a small MMIO window
// (LED, switch, timer, scratch), one-cycle registered read data, never stalls.
module data_sram_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch
);

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_SCRATCH = 16'h000C;

    logic [31:0] mem_q [0:(1 << RAM_AW) - 1];

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] scratch_q, scratch_d;
    logic [7:0]  sw_meta_q, sw_sync_q;

    logic              mmio_hit;
    logic              wr_req;
    logic              rd_req;
    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]       mmio_off;
    logic [31:0]       mmio_rdata;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
        mmio_off = data_sram_addr[15:0];
        ram_idx  = data_sram_addr[RAM_AW+1:2];
        wr_req   = data_sram_en && (data_sram_we != 4'b0000);
        rd_req   = data_sram_en && (data_sram_we == 4'b0000);
    end

    // Timer reads return the pre-edge count, so the live register is muxed directly.
    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            OFF_LED:     mmio_rdata = {16'h0, led_q};
            OFF_SWITCH:  mmio_rdata = {24'h0, sw_sync_q};
            OFF_TIMER:   mmio_rdata = timer_q;
            OFF_SCRATCH: mmio_rdata = scratch_q;
            default:     mmio_rdata = 32'h0;
        endcase
    end

    always_comb begin
        rdata_d   = rdata_q;
        led_d     = led_q;
        scratch_d = scratch_q;
        timer_d   = timer_q + 32'd1;

        if (rd_req) begin
            rdata_d = mmio_hit ? mmio_rdata : mem_q[ram_idx];
        end

        if (wr_req && mmio_hit) begin
            case (mmio_off)
                OFF_LED: begin
                    if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
                    if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
                end
                OFF_TIMER:   timer_d   = byte_merge(timer_q, data_sram_wdata, data_sram_we);
                OFF_SCRATCH: scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_we);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= 32'h0;
            led_q     <= 16'h0;
            timer_q   <= 32'h0;
            scratch_q <= 32'h0;
            sw_meta_q <= 8'h0;
            sw_sync_q <= 8'h0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto plain memory and keeps
    // its contents across reset; writes are still blocked while reset is high.
    always_ff @(posedge clk) begin
        if (wr_req && !mmio_hit && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) mem_q[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: RAM, byte lanes, aliasing, MMIO, timer, reset.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led;
    logic [7:0]  switch;

    int checks = 0;
    int errors = 0;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .led             (led),
        .switch          (switch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request presented for exactly one edge; returns 1 time unit after it.
    task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        data_sram_en    = 1'b1;
        data_sram_we    = w;
        data_sram_addr  = a;
        data_sram_wdata = d;
        @(posedge clk);
        #1;
        data_sram_en    = 1'b0;
        data_sram_we    = 4'h0;
        data_sram_wdata = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        data_sram_en    = 1'b0;
        data_sram_we    = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        switch          = 8'h00;

        idle(2);
        check("reset_rdata", data_sram_rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        reset = 1'b0;

        req(4'hf, 32'h0000_0100, 32'h1234_5678);
        req(4'h0, 32'h0000_0100, 32'h0);
        check("ram_full_word", data_sram_rdata, 32'h1234_5678);

        req(4'b0100, 32'h0000_0100, 32'hAABB_CCDD);
        check("write_keeps_rdata", data_sram_rdata, 32'h1234_5678);
        req(4'h0, 32'h0000_0100, 32'h0);
        check("ram_byte_lane", data_sram_rdata, 32'h12BB_5678);

        idle(2);
        check("idle_keeps_rdata", data_sram_rdata, 32'h12BB_5678);

        req(4'hf, 32'h1C00_0000, 32'hCAFE_F00D);
        check("write2_keeps_rdata", data_sram_rdata, 32'h12BB_5678);
        req(4'h0, 32'h1C00_4000, 32'h0);
        check("ram_wrap_alias", data_sram_rdata, 32'hCAFE_F00D);

        for (int i = 0; i < 4; i++) begin
            req(4'h0, (i % 2 == 0) ? 32'h0000_0100 : 32'h1C00_0000, 32'h0);
            check("b2b_alternate", data_sram_rdata, (i % 2 == 0) ? 32'h12BB_5678 : 32'hCAFE_F00D);
        end

        req(4'hf, 32'hbfaf_0000, 32'h0000_FFFF);
        check("led_write", {16'h0, led}, 32'h0000_FFFF);
        req(4'b0010, 32'hbfaf_0000, 32'h0000_1234);
        check("led_byte1", {16'h0, led}, 32'h0000_12FF);
        req(4'h0, 32'hbfaf_0000, 32'h0);
        check("led_read", data_sram_rdata, 32'h0000_12FF);

        switch = 8'h5A;
        idle(2);
        req(4'h0, 32'hbfaf_0004, 32'h0);
        check("switch_read", data_sram_rdata, 32'h0000_005A);
        req(4'hf, 32'hbfaf_0004, 32'hFFFF_FFFF);
        req(4'h0, 32'hbfaf_0004, 32'h0);
        check("switch_ro", data_sram_rdata, 32'h0000_005A);

        req(4'h0, 32'hbfaf_0010, 32'h0);
        check("mmio_hole", data_sram_rdata, 32'h0);

        req(4'hf, 32'hbfaf_000C, 32'hDEAD_BEEF);
        req(4'b0001, 32'hbfaf_000C, 32'h0000_0011);
        req(4'h0, 32'hbfaf_000C, 32'h0);
        check("scratch_merge", data_sram_rdata, 32'hDEAD_BE11);

        req(4'hf, 32'hbfaf_0008, 32'hFFFF_FFFE);
        req(4'h0, 32'hbfaf_0008, 32'h0);
        check("timer_load", data_sram_rdata, 32'hFFFF_FFFE);
        req(4'h0, 32'hbfaf_0008, 32'h0);
        check("timer_inc", data_sram_rdata, 32'hFFFF_FFFF);
        req(4'h0, 32'hbfaf_0008, 32'h0);
        check("timer_wrap", data_sram_rdata, 32'h0000_0000);

        req(4'h0, 32'h0000_0100, 32'h0);
        check("pre_reset_read", data_sram_rdata, 32'h12BB_5678);
        reset = 1'b1;
        #1;
        check("async_rdata_clear", data_sram_rdata, 32'h0);
        check("async_led_clear", {16'h0, led}, 32'h0);
        req(4'hf, 32'h0000_0100, 32'h5555_5555);
        req(4'h0, 32'h0000_0100, 32'h0);
        check("reset_ignores_read", data_sram_rdata, 32'h0);
        reset = 1'b0;

        req(4'h0, 32'hbfaf_0008, 32'h0);
        check("timer_after_reset", data_sram_rdata, 32'h0);
        req(4'h0, 32'hbfaf_0008, 32'h0);
        check("timer_counts_again", data_sram_rdata, 32'h1);
        req(4'h0, 32'hbfaf_000C, 32'h0);
        check("scratch_after_reset", data_sram_rdata, 32'h0);
        req(4'h0, 32'h0000_0100, 32'h0);
        check("ram_survives_reset", data_sram_rdata, 32'h12BB_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
